// File: rtl/q_event_monitor_pkg.sv
// ============================================================================
// Module   : q_event_monitor_pkg
// Purpose  : Shared types, default constants and the saturating-increment
//            helper used by the q_event_monitor block.
// Contents : state_t                - window FSM encoding (IDLE, COUNT)
//            DEFAULT_WINDOW_CYCLES  - default window length in clocks
//            DEFAULT_COUNT_W        - default edge counter width
//            sat_inc()              - increment that sticks at a ceiling
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package q_event_monitor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_WINDOW_CYCLES = 16;
  localparam int DEFAULT_COUNT_W       = 8;

  // Adds inc to value but never exceeds max_value. Operands are carried at
  // 32 bits so a single function serves any counter width up to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic        inc,
                                          input logic [31:0] max_value);
    if (inc && (value < max_value)) begin
      return value + 32'd1;
    end
    return value;
  endfunction

endpackage : q_event_monitor_pkg

`default_nettype wire

// File: rtl/q_event_monitor_edge_detect.sv
// ============================================================================
// Module   : q_edge_detect
// Purpose  : Rising-edge detector for the monitored bit, with an optional
//            two-flop synchronizer in front of it.
// Macro    : Q_EVENT_MONITOR_SYNC_EN - when defined, q_in is synchronized
//            through two reset-to-0 flops before edge detection (adds two
//            cycles of input latency).
// Ports    : clk   in  rising-edge clock
//            rst   in  asynchronous active-high reset
//            q_in  in  monitored bit
//            rise  out high for the cycle in which the (synchronized) bit
//                      is 1 and its previous-cycle value was 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic rise
);

  logic q_s;
  logic q_d;

`ifdef Q_EVENT_MONITOR_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= q_in;
      sync_2 <= sync_1;
    end
  end

  assign q_s = sync_2;
`else
  // Upstream is a same-clock register, so no synchronization is needed.
  assign q_s = q_in;
`endif

  // Previous-cycle copy; tracked in every FSM state so the first counted
  // cycle sees a correct history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_d <= 1'b0;
    end else begin
      q_d <= q_s;
    end
  end

  assign rise = q_s && !q_d;

endmodule : q_edge_detect

`default_nettype wire

// File: rtl/q_event_monitor.sv
// ============================================================================
// Module   : q_event_monitor
// Purpose  : Counts rising edges of q_in over back-to-back windows of
//            WINDOW_CYCLES clocks and hands each window's count out through
//            a valid/ready result register. A result that arrives while the
//            previous one is still unaccepted is dropped and recorded in the
//            sticky overrun_out flag.
// Macro    : Q_EVENT_MONITOR_SYNC_EN - adds a 2-flop synchronizer on q_in
//            (see q_edge_detect). Window timing is unaffected.
// Params   : WINDOW_CYCLES - window length in clocks (>= 2)
//            COUNT_W       - edge counter / count_out width (1..32),
//                            counter saturates at 2^COUNT_W-1
// Ports    : clk            in  rising-edge clock
//            rst            in  asynchronous active-high reset
//            q_in           in  monitored bit
//            enable_in      in  run windows while high
//            ready_in       in  consumer accepts count_out
//            clear_in       in  pulse: clears overrun_out
//            count_out      out edge count of last completed window
//            valid_out      out count_out holds an unaccepted result
//            overrun_out    out sticky: a window result was dropped
//            window_end_out out pulse on the terminal cycle of each window
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_event_monitor
  import q_event_monitor_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int COUNT_W       = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_in,
  input  logic               enable_in,
  input  logic               ready_in,
  input  logic               clear_in,
  output logic [COUNT_W-1:0] count_out,
  output logic               valid_out,
  output logic               overrun_out,
  output logic               window_end_out
);

  localparam int                 WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  state_t             state;
  state_t             state_next;
  logic [WIN_W-1:0]   window_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] final_count;
  logic               rise;
  logic               terminal;

  q_edge_detect u_edge_detect (
    .clk  (clk),
    .rst  (rst),
    .q_in (q_in),
    .rise (rise)
  );

  // Count including this cycle's rise; on the terminal cycle this is the
  // window result, otherwise it is the next edge_cnt value.
  assign final_count = COUNT_W'(sat_inc(32'(edge_cnt), rise, 32'(CNT_MAX)));

  always_comb begin
    state_next = state;
    terminal   = 1'b0;
    case (state)
      IDLE: begin
        if (enable_in) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!enable_in) begin
          state_next = IDLE;
        end else if (window_cnt == WIN_LAST) begin
          terminal = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign window_end_out = terminal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Window/edge counters. Anything other than a running, non-terminal COUNT
  // cycle returns them to zero, which covers IDLE, abort and window wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_cnt <= '0;
      edge_cnt   <= '0;
    end else if ((state == COUNT) && enable_in && !terminal) begin
      window_cnt <= window_cnt + WIN_W'(1);
      edge_cnt   <= final_count;
    end else begin
      window_cnt <= '0;
      edge_cnt   <= '0;
    end
  end

  // Result register. A terminal cycle either loads (slot free or being
  // emptied this same edge) or drops the result; otherwise a transfer
  // simply empties the slot. count_out is left untouched when emptied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
      valid_out <= 1'b0;
    end else if (terminal && (!valid_out || ready_in)) begin
      count_out <= final_count;
      valid_out <= 1'b1;
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

  // A drop takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_out <= 1'b0;
    end else if (terminal && valid_out && !ready_in) begin
      overrun_out <= 1'b1;
    end else if (clear_in) begin
      overrun_out <= 1'b0;
    end
  end

endmodule : q_event_monitor

`default_nettype wire

// File: tb/tb_q_event_monitor.sv
// ============================================================================
// Module   : tb_q_event_monitor
// Purpose  : Directed self-checking bench for q_event_monitor. A second
//            instance with COUNT_W=2 shares the stimulus to exercise
//            counter saturation. Expected window counts are queued when a
//            window is driven and popped when the result appears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_in;
  logic       enable_in;
  logic       ready_in;
  logic       clear_in;
  logic [7:0] count_out;
  logic       valid_out;
  logic       overrun_out;
  logic       window_end_out;
  logic [1:0] count2;
  logic       valid2;
  logic       overrun2;
  logic       wend2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int unsigned sb[$];
  int unsigned sb2[$];

  logic       v_after0;
  logic       term_valid;
  logic [7:0] term_count;

  always #5 clk = ~clk;

  q_event_monitor #(.WINDOW_CYCLES(16), .COUNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .q_in           (q_in),
    .enable_in      (enable_in),
    .ready_in       (ready_in),
    .clear_in       (clear_in),
    .count_out      (count_out),
    .valid_out      (valid_out),
    .overrun_out    (overrun_out),
    .window_end_out (window_end_out)
  );

  q_event_monitor #(.WINDOW_CYCLES(16), .COUNT_W(2)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .q_in           (q_in),
    .enable_in      (enable_in),
    .ready_in       (ready_in),
    .clear_in       (clear_in),
    .count_out      (count2),
    .valid_out      (valid2),
    .overrun_out    (overrun2),
    .window_end_out (wend2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window: pat[i] is q_in on window cycle i.
  task automatic run_window(input logic [15:0] pat, input logic rdy_body,
                            input logic rdy_term, input logic clr_term);
    for (int i = 0; i < 16; i++) begin
      q_in      = pat[i];
      enable_in = 1'b1;
      ready_in  = (i == 15) ? rdy_term : rdy_body;
      clear_in  = (i == 15) ? clr_term : 1'b0;
      #1;
      if (i == 14) chk("wend_c14", 32'(window_end_out), 0);
      if (i == 15) begin
        chk("wend_term", 32'(window_end_out), 1);
        term_valid = valid_out;
        term_count = count_out;
      end
      tick();
      if (i == 0) v_after0 = valid_out;
    end
    clear_in = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    q_in      = 1'b0;
    enable_in = 1'b0;
    ready_in  = 1'b0;
    clear_in  = 1'b0;
    #2;
    chk("rst_count",   32'(count_out),      0);
    chk("rst_valid",   32'(valid_out),      0);
    chk("rst_overrun", 32'(overrun_out),    0);
    chk("rst_wend",    32'(window_end_out), 0);
    #1;
    rst       = 1'b0;
    enable_in = 1'b1;
    tick();  // IDLE -> COUNT, window cycle 0 follows

    // Toggle pattern: rises on every even cycle -> 8 (saturates to 3 at 2 bits)
    sb.push_back(8);
    sb2.push_back(3);
    run_window(16'h5555, 1'b1, 1'b1, 1'b0);
    chk("toggle_count", 32'(count_out), sb.pop_front());
    chk("toggle_valid", 32'(valid_out), 1);
    chk("sat_count",    32'(count2),    sb2.pop_front());

    // Single rise exactly on the terminal cycle
    sb.push_back(1);
    sb2.push_back(1);
    run_window(16'h8000, 1'b1, 1'b1, 1'b0);
    chk("xfer_clears_valid", 32'(v_after0),  0);
    chk("boundary_count",    32'(count_out), sb.pop_front());
    chk("boundary_valid",    32'(valid_out), 1);
    chk("sat_boundary",      32'(count2),    sb2.pop_front());

    // q held high across the window: no new rise
    sb.push_back(0);
    run_window(16'hFFFF, 1'b1, 1'b1, 1'b0);
    chk("held_high_count", 32'(count_out), sb.pop_front());
    chk("held_high_valid", 32'(valid_out), 1);

    // Backpressure then accept on the terminal cycle: accept and load together
    sb.push_back(2);
    run_window(16'h0218, 1'b0, 1'b1, 1'b0);
    chk("stall_valid_hold", 32'(v_after0),   1);
    chk("stall_term_valid", 32'(term_valid), 1);
    chk("stall_term_count", 32'(term_count), 0);
    chk("accload_count",    32'(count_out),  sb.pop_front());
    chk("accload_valid",    32'(valid_out),  1);
    chk("accload_overrun",  32'(overrun_out), 0);

    // Full window of backpressure: result dropped, clear in same cycle loses
    run_window(16'h5555, 1'b0, 1'b0, 1'b1);
    chk("drop_term_count", 32'(term_count),  2);
    chk("drop_count_kept", 32'(count_out),   2);
    chk("drop_valid",      32'(valid_out),   1);
    chk("drop_overrun",    32'(overrun_out), 1);

    // Disable plus clear: overrun clears, pending result survives
    enable_in = 1'b0;
    clear_in  = 1'b1;
    ready_in  = 1'b0;
    q_in      = 1'b0;
    tick();
    clear_in = 1'b0;
    chk("clear_overrun",   32'(overrun_out), 0);
    chk("idle_keep_valid", 32'(valid_out),   1);
    chk("idle_keep_count", 32'(count_out),   2);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("idle_xfer_valid", 32'(valid_out), 0);
    chk("idle_xfer_count", 32'(count_out), 2);

    // Abort at window cycle 7: no result
    enable_in = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      q_in = (i % 2 == 0);
      tick();
    end
    enable_in = 1'b0;
    q_in      = 1'b0;
    #1;
    chk("abort_wend", 32'(window_end_out), 0);
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_valid", 32'(valid_out), 0);

    // Re-enable: full 16-cycle window with one rise at cycle 5
    enable_in = 1'b1;
    tick();
    sb.push_back(1);
    run_window(16'h0060, 1'b0, 1'b0, 1'b0);
    chk("reen_count", 32'(count_out), sb.pop_front());
    chk("reen_valid", 32'(valid_out), 1);

    // Asynchronous reset while a result is pending
    enable_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid_out), 0);
    chk("async_rst_count", 32'(count_out), 0);
    #3;
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_q_event_monitor

`default_nettype wire
